// File: rtl/vga_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_if
// Purpose  : Bundles the scan-out side of the VGA timing generator: the
//            address bus offered to sprite renderers, the pixel they return,
//            and the sync/colour outputs heading to the DAC.
// Ports    : px       - renderer pixel (renderer -> scanner)
//            row_addr - current visible row
//            col_addr - current visible column
//            fresh    - high during visible lines
//            hs, vs   - active-low syncs
//            rgb      - {R,G,B} 4 bits each
// Modports : master (scanner side), slave (renderer / DAC side)
// Revision : 1.0 - initial release
// ============================================================================
interface vga_scan_if;
  logic        px;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        fresh;
  logic        hs;
  logic        vs;
  logic [11:0] rgb;

  modport master (
    input  px,
    output row_addr,
    output col_addr,
    output fresh,
    output hs,
    output vs,
    output rgb
  );

  modport slave (
    output px,
    input  row_addr,
    input  col_addr,
    input  fresh,
    input  hs,
    input  vs,
    input  rgb
  );
endinterface
`default_nettype wire

// File: rtl/vga_scan.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan
// Purpose  : Free-running VGA raster generator. A clock divider produces a
//            one-CLK pixel enable; horizontal/vertical counters advance on it.
//            Addresses for the next pixel are issued on each enable, and the
//            renderer's reply for the current pixel is sampled on the next
//            enable together with syncs, so colour and sync never skew.
// Ports    : CLK   - system clock, rising edge
//            RESET - asynchronous, active-high reset
//            vga   - vga_scan_if.master (px in; addresses, fresh, hs, vs,
//                    rgb out)
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  wire logic  CLK,
  input  wire logic  RESET,
  vga_scan_if.master vga
);

  // Sync windows are half-open: [start, end).
  localparam logic [2:0] c_div_max  = 3'(CLK_DIV - 1);
  localparam logic [9:0] c_h_last   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_v_last   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_h_vis    = 10'(H_VIS);
  localparam logic [9:0] c_v_vis    = 10'(V_VIS);
  localparam logic [9:0] c_hs_start = 10'(H_VIS + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_start = 10'(V_VIS + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_VIS + V_FP + V_SYNC);

  logic [2:0]  r_div;
  logic [9:0]  r_h;
  logic [9:0]  r_v;

  logic        w_pe;
  logic        w_h_wrap;
  logic [9:0]  w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_vis;
  logic        w_hs_n;
  logic        w_vs_n;
  logic [11:0] w_rgb;

  always_comb begin
    w_pe     = (r_div == c_div_max);
    w_h_wrap = (r_h == c_h_last);
    w_h_nxt  = w_h_wrap ? 10'd0 : r_h + 10'd1;
    w_v_nxt  = r_v;
    if (w_h_wrap) begin
      w_v_nxt = (r_v == c_v_last) ? 10'd0 : r_v + 10'd1;
    end

    // Syncs and colour describe the pixel being left (current h/v), while
    // addresses describe the pixel being entered (next h/v).
    w_vis  = (r_h < c_h_vis) && (r_v < c_v_vis);
    w_hs_n = !((r_h >= c_hs_start) && (r_h < c_hs_end));
    w_vs_n = !((r_v >= c_vs_start) && (r_v < c_vs_end));
    w_rgb  = 12'h000;
    if (w_vis) begin
      w_rgb = vga.px ? 12'h555 : 12'hFFF;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_div        <= 3'd0;
      r_h          <= 10'd0;
      r_v          <= 10'd0;
      vga.row_addr <= 9'd0;
      vga.col_addr <= 10'd0;
      vga.fresh    <= 1'b0;
      vga.hs       <= 1'b1;
      vga.vs       <= 1'b1;
      vga.rgb      <= 12'h000;
    end else begin
      r_div <= w_pe ? 3'd0 : r_div + 3'd1;
      if (w_pe) begin
        r_h          <= w_h_nxt;
        r_v          <= w_v_nxt;
        vga.col_addr <= (w_h_nxt < c_h_vis) ? w_h_nxt : 10'd0;
        vga.row_addr <= (w_v_nxt < c_v_vis) ? w_v_nxt[8:0] : 9'd0;
        vga.fresh    <= (w_v_nxt < c_v_vis);
        vga.hs       <= w_hs_n;
        vga.vs       <= w_vs_n;
        vga.rgb      <= w_rgb;
      end
    end
  end

endmodule
`default_nettype wire
